// File: rtl/core_pkg.sv
// Shared definitions for the machine timer: register offsets, bus FSM states
// and the byte-enable merge used for partial register writes.
package core_pkg;

  localparam logic [3:0] MTIMER_MTIME_LO = 4'h0;
  localparam logic [3:0] MTIMER_MTIME_HI = 4'h4;
  localparam logic [3:0] MTIMER_CMP_LO   = 4'h8;
  localparam logic [3:0] MTIMER_CMP_HI   = 4'hC;

  typedef enum logic [0:0] {
    MTIMER_IDLE = 1'b0,
    MTIMER_RESP = 1'b1
  } mtimer_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/core_mtimer_if.sv
// Word bus between the memory interface (master) and the machine timer (slave).
interface core_mtimer_if;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_write;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport master (
    output bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata, bus_error
  );

  modport slave (
    input  bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata, bus_error
  );

endinterface

// File: rtl/core_mtimer_prescaler.sv
// Free-running divider: tick is high on the last of every PRESCALE cycles.
module core_mtimer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a one-wait-state word bus,
// driving a registered level interrupt while mtime >= mtimecmp.
module core_mtimer
  import core_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  core_mtimer_if.slave    bus,
  output logic            mtimer_int
);

  mtimer_state_e state_q, state_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;
  logic          int_q, int_d;
  logic          tick;
  logic          ready;
  logic          misaligned;
  logic [31:0]   sel_word;

  core_mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign ready = (state_q == MTIMER_RESP);

  always_comb begin
    state_d    = state_q;
    mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
    cmp_d      = cmp_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    int_d      = (mtime_q >= cmp_q);
    misaligned = |bus.bus_addr[1:0];

    // Misaligned offsets match no register, so they read as zero and write nothing.
    case (bus.bus_addr)
      MTIMER_MTIME_LO: sel_word = mtime_q[31:0];
      MTIMER_MTIME_HI: sel_word = mtime_q[63:32];
      MTIMER_CMP_LO:   sel_word = cmp_q[31:0];
      MTIMER_CMP_HI:   sel_word = cmp_q[63:32];
      default:         sel_word = '0;
    endcase

    case (state_q)
      MTIMER_IDLE: begin
        if (bus.bus_valid && !ready) begin
          state_d = MTIMER_RESP;
          error_d = misaligned;
          rdata_d = sel_word;
          // An mtime write replaces the whole incremented value, dropping this tick and its carry.
          if (bus.bus_write) begin
            case (bus.bus_addr)
              MTIMER_MTIME_LO: mtime_d = {mtime_q[63:32],
                                          byte_merge(mtime_q[31:0], bus.bus_wdata, bus.bus_wstrb)};
              MTIMER_MTIME_HI: mtime_d = {byte_merge(mtime_q[63:32], bus.bus_wdata, bus.bus_wstrb),
                                          mtime_q[31:0]};
              MTIMER_CMP_LO:   cmp_d   = {cmp_q[63:32],
                                          byte_merge(cmp_q[31:0], bus.bus_wdata, bus.bus_wstrb)};
              MTIMER_CMP_HI:   cmp_d   = {byte_merge(cmp_q[63:32], bus.bus_wdata, bus.bus_wstrb),
                                          cmp_q[31:0]};
              default: ;
            endcase
          end
        end
      end
      MTIMER_RESP: state_d = MTIMER_IDLE;
      default:     state_d = MTIMER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MTIMER_IDLE;
      mtime_q <= '0;
      cmp_q   <= RESET_CMP;
      rdata_q <= '0;
      error_q <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      int_q   <= int_d;
    end
  end

  assign bus.bus_ready = ready;
  assign bus.bus_rdata = rdata_q;
  assign bus.bus_error = error_q;
  assign mtimer_int    = int_q;

endmodule

// File: tb/tb_core_mtimer.sv
// Bench for core_mtimer: one instance at PRESCALE=1 and one at PRESCALE=4,
// checked against a cycle-level arithmetic model of mtime/mtimecmp.
module tb_core_mtimer;

  localparam logic [63:0] RCMP = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_mtimer_if if1();
  core_mtimer_if if4();
  logic int1, int4;

  core_mtimer #(.PRESCALE(1), .RESET_CMP(RCMP)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .mtimer_int(int1));
  core_mtimer #(.PRESCALE(4), .RESET_CMP(RCMP)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .mtimer_int(int4));

  logic        sel = 1'b0;
  logic        valid = 1'b0, write = 1'b0;
  logic [3:0]  addr = 4'h0, strb = 4'h0;
  logic [31:0] wdata = 32'h0;

  assign if1.bus_valid = valid && !sel;
  assign if4.bus_valid = valid && sel;
  assign if1.bus_write = write;  assign if4.bus_write = write;
  assign if1.bus_addr  = addr;   assign if4.bus_addr  = addr;
  assign if1.bus_wdata = wdata;  assign if4.bus_wdata = wdata;
  assign if1.bus_wstrb = strb;   assign if4.bus_wstrb = strb;

  logic        rdy, rerr;
  logic [31:0] rdat;
  assign rdy  = sel ? if4.bus_ready : if1.bus_ready;
  assign rerr = sel ? if4.bus_error : if1.bus_error;
  assign rdat = sel ? if4.bus_rdata : if1.bus_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m[2];
  logic [63:0] c[2];
  int          k[2];
  logic        im[2];
  logic        pend_v = 1'b0;
  int          pend_d;
  logic [3:0]  pend_a, pend_s;
  logic [31:0] pend_w;
  logic [63:0] nm;
  logic        tk;
  logic        mon_en = 1'b0;

  function automatic int per(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [3:0] a);
    case (a)
      4'h0: return m[d][31:0];
      4'h4: return m[d][63:32];
      4'h8: return c[d][31:0];
      4'hC: return c[d][63:32];
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin m[d] = 0; c[d] = RCMP; k[d] = 0; im[d] = 1'b0; end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m[d] = 64'h0; c[d] = RCMP; k[d] = 0; im[d] = 1'b0;
      end else begin
        tk = ((k[d] % per(d)) == per(d) - 1);
        k[d] = k[d] + 1;
        im[d] = (m[d] >= c[d]);
        nm = tk ? m[d] + 64'd1 : m[d];
        if (pend_v && pend_d == d && pend_a[1:0] == 2'b00) begin
          case (pend_a)
            4'h0: nm = {m[d][63:32], mrg(m[d][31:0], pend_w, pend_s)};
            4'h4: nm = {mrg(m[d][63:32], pend_w, pend_s), m[d][31:0]};
            4'h8: c[d][31:0]  = mrg(c[d][31:0], pend_w, pend_s);
            4'hC: c[d][63:32] = mrg(c[d][63:32], pend_w, pend_s);
            default: ;
          endcase
        end
        m[d] = nm;
      end
    end
    pend_v = 1'b0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("int_p1", int1, im[0]);
      check("int_p4", int4, im[1]);
    end
  end

  // Starts at a negedge with the slave idle; returns two cycles later at a negedge.
  task automatic access(input int d, input logic w, input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    sel = (d != 0); valid = 1'b1; write = w; addr = a; wdata = wd; strb = s;
    exp_er = (a[1:0] != 2'b00);
    exp_rd = exp_er ? 32'h0 : mword(d, a);
    if (w) begin pend_v = 1'b1; pend_d = d; pend_a = a; pend_w = wd; pend_s = s; end
    @(negedge clk);
    check("ready_pulse", rdy, 1'b1);
    check("error", rerr, exp_er);
    if (!w) check("rdata", rdat, exp_rd);
    rd = rdat; er = rerr;
    valid = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", rdy, 1'b0);
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  logic        er;
  logic        found;
  int          gap;

  initial begin
    tbl.push_back('{1, 1'b1, 4'h8, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b1, 4'h8, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 4'h8, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0});
    tbl.push_back('{1, 1'b0, 4'h2, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{1, 1'b1, 4'hA, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{1, 1'b0, 4'h8, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0});
    tbl.push_back('{1, 1'b1, 4'hC, 32'h1234_5678, 4'h0, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 4'hC, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1, 1'b1, 4'hC, 32'h1234_5678, 4'h8, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 4'hC, 32'h0,         4'h0, 1'b1, 32'h12FF_FFFF, 1'b0});
    tbl.push_back('{0, 1'b1, 4'h1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 4'hD, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready1", if1.bus_ready, 1'b0); check("rst_ready4", if4.bus_ready, 1'b0);
    check("rst_rdata1", if1.bus_rdata, 32'h0); check("rst_rdata4", if4.bus_rdata, 32'h0);
    check("rst_err1", if1.bus_error, 1'b0);   check("rst_err4", if4.bus_error, 1'b0);
    check("rst_int1", int1, 1'b0);            check("rst_int4", int4, 1'b0);
    mon_en = 1'b1;

    // First access right out of reset sees mtime=0, then ~100 cycles later
    rst = 1'b0;
    access(0, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("mtime_first", rd, 32'h0);
    repeat (100) @(negedge clk);
    access(0, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("mtime_100_range", (rd >= 32'd98 && rd <= 32'd102), 1'b1);

    // Interrupt rises one cycle after mtime reaches mtimecmp, falls after raising it
    access(0, 1'b1, 4'h0, 32'h0, 4'hF, rd, er);
    access(0, 1'b1, 4'hC, 32'h0, 4'hF, rd, er);
    access(0, 1'b1, 4'h8, 32'd20, 4'hF, rd, er);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (int1) found = 1'b1;
      else @(negedge clk);
    end
    check("int_rise_seen", found, 1'b1);
    if (found) check("int_rise_mtime", m[0], 64'd21);
    access(0, 1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("int_fall", int1, 1'b0);

    // Carry from low to high word
    access(0, 1'b1, 4'h4, 32'h0, 4'hF, rd, er);
    access(0, 1'b1, 4'h0, 32'hFFFF_FFFE, 4'hF, rd, er);
    @(negedge clk);
    access(0, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("carry_lo", rd, 32'h0);
    access(0, 1'b0, 4'h4, 32'h0, 4'h0, rd, er);
    check("carry_hi", rd, 32'h1);

    // PRESCALE=4: write on a tick cycle drops the increment, phase is kept
    access(1, 1'b1, 4'h4, 32'h0, 4'hF, rd, er);
    for (int i = 0; i < 8 && (k[1] % 4) != 3; i++) @(negedge clk);
    check("tick_phase_found", k[1] % 4, 3);
    access(1, 1'b1, 4'h0, 32'h0, 4'hF, rd, er);
    access(1, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("p4_after_write", rd, 32'h0);
    access(1, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("p4_before_tick", rd, 32'h0);
    access(1, 1'b0, 4'h0, 32'h0, 4'h0, rd, er);
    check("p4_after_tick", rd, 32'h1);

    // Table: byte strobes, misaligned errors, no-op strobes
    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, rd, er);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        check($sformatf("vec%0d_err", i), er, tbl[i].exp_er);
      end
    end

    // Reset while the response is on the bus
    sel = 1'b0; valid = 1'b1; write = 1'b0; addr = 4'h8;
    @(negedge clk);
    check("resp_before_rst", rdy, 1'b1);
    check("resp_rdata_before_rst", rdat, 32'hFFFF_FFFF);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", if1.bus_ready, 1'b0);
    check("rst_mid_rdata", if1.bus_rdata, 32'h0);
    check("rst_mid_int", int1, 1'b0);
    rst = 1'b0;
    // Reset arriving with the request: no response at all
    sel = 1'b1; valid = 1'b1; write = 1'b0; addr = 4'h6; rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", if4.bus_ready, 1'b0);
    check("rst_req_err", if4.bus_error, 1'b0);
    valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_req_no_late_ready", if4.bus_ready, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             $urandom, 4'($urandom_range(0, 15)), rd, er);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
